// File: rtl/tagger_pkg.sv
// Shared types and constants for the tagger record reader.
// Build option RECORD_MARKER_EN appends a fixed marker word after each record.
package tagger_pkg;

  localparam int REC_W  = 47;
  localparam int WORD_W = 16;

`ifdef RECORD_MARKER_EN
  localparam int WORDS_PER_REC = 4;
`else
  localparam int WORDS_PER_REC = 3;
`endif

  localparam logic [15:0] MARKER_WORD = 16'hA5A5;

`ifdef RECORD_MARKER_EN
  typedef enum logic [2:0] {ST_IDLE, ST_W0, ST_W1, ST_W2, ST_W3} reader_state_e;
  localparam reader_state_e ST_LAST = ST_W3;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_W0, ST_W1, ST_W2} reader_state_e;
  localparam reader_state_e ST_LAST = ST_W2;
`endif

  // Words still owed to the host for the record currently being serialized.
  function automatic logic [2:0] words_left(input reader_state_e s);
    case (s)
      ST_W0:   words_left = 3'(WORDS_PER_REC);
      ST_W1:   words_left = 3'(WORDS_PER_REC - 1);
      ST_W2:   words_left = 3'(WORDS_PER_REC - 2);
`ifdef RECORD_MARKER_EN
      ST_W3:   words_left = 3'd1;
`endif
      default: words_left = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tagger_record_reader_fifo.sv
// Single-clock record FIFO. The head record is only presented on rd_data_o
// after it has been popped, so the output register doubles as the reader's
// record holding register.
module record_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 47
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [W-1:0]        wr_data_i,
  input  logic                pop_i,
  output logic [W-1:0]        rd_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [W-1:0]          rd_data_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

  // Pointer, occupancy and read-register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2)'(1);
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + (DEPTH_LOG2)'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/tagger_record_reader.sv
// Tagger record reader: buffers engine record strobes and serializes each
// record into host words over a valid/ack handshake. With RECORD_MARKER_EN
// defined, every record is followed by MARKER_WORD.
module tagger_record_reader
  import tagger_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int REC_W      = 47,
  parameter int WORD_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              record_rdy,
  input  logic [REC_W-1:0]  record,
  output logic [WORD_W-1:0] data,
  output logic              data_rdy,
  input  logic              data_ack,
  input  logic              request_length,
  output logic [15:0]       length,
  output logic              length_rdy,
  output logic              overflow,
  output logic [15:0]       lost_count
);

  localparam int SR_W = 3 * WORD_W;

  reader_state_e       state_q;
  logic                data_rdy_q;
  logic [15:0]         length_q;
  logic                length_rdy_q;
  logic                overflow_q;
  logic [15:0]         lost_q;

  logic [REC_W-1:0]    fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_pop;
  logic                dropped;
  logic [SR_W-1:0]     rec_ext;
  logic [WORD_W-1:0]   data_mux;
  logic [31:0]         len_full;
  logic [15:0]         len_d;

  record_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (record_rdy),
    .wr_data_i (record),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign fifo_pop = !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_LAST) && data_ack));
  assign dropped  = record_rdy && fifo_full && !fifo_pop;
  assign rec_ext  = {{(SR_W-REC_W){1'b0}}, fifo_rd_data};

  // Serializer sequencing; data_rdy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          state_q    <= ST_W0;
          data_rdy_q <= 1'b1;
        end
        ST_W0: if (data_ack) state_q <= ST_W1;
        ST_W1: if (data_ack) state_q <= ST_W2;
`ifdef RECORD_MARKER_EN
        ST_W2: if (data_ack) state_q <= ST_W3;
        ST_W3: if (data_ack) begin
`else
        ST_W2: if (data_ack) begin
`endif
          if (fifo_empty) begin
            state_q    <= ST_IDLE;
            data_rdy_q <= 1'b0;
          end else begin
            state_q    <= ST_W0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          data_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // Word select from the held record; zero when nothing is being offered.
  always_comb begin
    data_mux = '0;
    case (state_q)
      ST_W0:   data_mux = rec_ext[WORD_W-1:0];
      ST_W1:   data_mux = rec_ext[2*WORD_W-1:WORD_W];
      ST_W2:   data_mux = rec_ext[3*WORD_W-1:2*WORD_W];
`ifdef RECORD_MARKER_EN
      ST_W3:   data_mux = WORD_W'(MARKER_WORD);
`endif
      default: data_mux = '0;
    endcase
  end

  assign len_full = 32'(WORDS_PER_REC) * 32'(fifo_count) + 32'(words_left(state_q));
  assign len_d    = (len_full > 32'h0000_FFFF) ? 16'hFFFF : len_full[15:0];

  // Length snapshot taken from pre-edge state, with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      length_q     <= '0;
      length_rdy_q <= 1'b0;
    end else begin
      length_rdy_q <= request_length;
      if (request_length) length_q <= len_d;
    end
  end

  // Sticky overflow flag and saturating count of dropped records.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      lost_q     <= '0;
    end else if (dropped) begin
      overflow_q <= 1'b1;
      if (lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
    end
  end

  assign data       = data_mux;
  assign data_rdy   = data_rdy_q;
  assign length     = length_q;
  assign length_rdy = length_rdy_q;
  assign overflow   = overflow_q;
  assign lost_count = lost_q;

endmodule

// File: tb/tb_tagger_record_reader.sv
// Scoreboard bench for tagger_record_reader: expected words are queued when
// a record is strobed in and checked as the reader hands them out.
module tb_tagger_record_reader;

`ifdef RECORD_MARKER_EN
  localparam int WPR = 4;
`else
  localparam int WPR = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        record_rdy;
  logic [46:0] record;
  logic [15:0] data;
  logic        data_rdy;
  logic        data_ack;
  logic        request_length;
  logic [15:0] length;
  logic        length_rdy;
  logic        overflow;
  logic [15:0] lost_count;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_q[$];

  tagger_record_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .record_rdy     (record_rdy),
    .record         (record),
    .data           (data),
    .data_rdy       (data_rdy),
    .data_ack       (data_ack),
    .request_length (request_length),
    .length         (length),
    .length_rdy     (length_rdy),
    .overflow       (overflow),
    .lost_count     (lost_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [46:0] r, input int k);
    logic [47:0] e;
    e = {1'b0, r};
    if (k == 3) return 16'hA5A5;
    return e[k*16 +: 16];
  endfunction

  function automatic logic [46:0] mk_rec(input int i);
    return {15'(i + 1), 16'hBEEF ^ 16'(i), 16'(i * 3)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [46:0] r, input bit accept);
    record_rdy = 1'b1;
    record     = r;
    if (accept)
      for (int k = 0; k < WPR; k++) exp_q.push_back(exp_word(r, k));
    step();
    record_rdy = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_done", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic wait_rdy(input int budget);
    for (int i = 0; i < budget && data_rdy !== 1'b1; i++) @(negedge clk);
    chk("rdy_timeout", 48'(data_rdy), 48'd1);
  endtask

  task automatic do_reset();
    step();
    rst_n    = 1'b0;
    data_ack = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Output monitor: every accepted word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && data_rdy && data_ack) begin
      if (exp_q.size() == 0) chk("extra_word", 48'(data_rdy), 48'd0);
      else                   chk("word", 48'(data), 48'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; record_rdy = 1'b0; record = '0;
    data_ack = 1'b0; request_length = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data",       48'(data),       48'd0);
    chk("rst_data_rdy",   48'(data_rdy),   48'd0);
    chk("rst_length",     48'(length),     48'd0);
    chk("rst_length_rdy", 48'(length_rdy), 48'd0);
    chk("rst_overflow",   48'(overflow),   48'd0);
    chk("rst_lost",       48'(lost_count), 48'd0);

    // single record, continuous ack
    step();
    data_ack = 1'b1;
    strobe(47'h1234_5678_9ABC, 1'b1);
    @(negedge clk) chk("lat_n1_rdy", 48'(data_rdy), 48'd0);
    step();
    @(negedge clk) chk("lat_n2_rdy", 48'(data_rdy), 48'd1);
    wait_drain(20);
    @(negedge clk) chk("single_idle", 48'(data_rdy), 48'd0);

    // backpressure: hold for 10 cycles, then release
    step();
    data_ack = 1'b0;
    strobe(47'h7FED_CBA9_8765, 1'b1);
    wait_rdy(10);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data", 48'(data), 48'(exp_q[0]));
      chk("bp_hold_rdy",  48'(data_rdy), 48'd1);
      step();
      @(negedge clk);
    end
    step();
    data_ack = 1'b1;
    wait_drain(20);

    // overflow: 20 strobes without ack, 17 fit (1 held + 16 buffered)
    step();
    data_ack = 1'b0;
    for (int i = 0; i < 20; i++) strobe(mk_rec(i), i < 17);
    @(negedge clk);
    chk("ovf_flag", 48'(overflow),   48'd1);
    chk("ovf_lost", 48'(lost_count), 48'd3);
    step();
    data_ack = 1'b1;
    wait_drain(200);
    repeat (3) step();
    @(negedge clk) chk("ovf_no_extra", 48'(data_rdy), 48'd0);

    // length snapshot: two buffered, third record in W1
    do_reset();
    for (int i = 0; i < 3; i++) strobe(mk_rec(100 + i), 1'b1);
    repeat (2) step();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    request_length = 1'b1;
    step();
    request_length = 1'b0;
    @(negedge clk);
    chk("len_value", 48'(length),     48'(2 * WPR + (WPR - 1)));
    chk("len_rdy",   48'(length_rdy), 48'd1);
    step();
    @(negedge clk) chk("len_rdy_pulse", 48'(length_rdy), 48'd0);
    data_ack = 1'b1;
    wait_drain(40);

    // full FIFO push on the same edge as the final-word ack
    do_reset();
    for (int i = 0; i < 17; i++) strobe(mk_rec(200 + i), 1'b1);
    repeat (3) step();
    data_ack = 1'b1;
    for (int k = 0; k < WPR - 1; k++) step();
    strobe(47'h0ACE_0F0F_5A5A, 1'b1);
    @(negedge clk);
    chk("simul_ovf",  48'(overflow),   48'd0);
    chk("simul_lost", 48'(lost_count), 48'd0);
    wait_drain(300);
    request_length = 1'b1;
    step();
    request_length = 1'b0;
    @(negedge clk) chk("simul_len_empty", 48'(length), 48'd0);

    // reset while a record is mid-transfer
    do_reset();
    data_ack = 1'b0;
    for (int i = 0; i < 3; i++) strobe(mk_rec(300 + i), 1'b1);
    wait_rdy(10);
    step();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_rdy",  48'(data_rdy),   48'd0);
    chk("mid_rst_lost", 48'(lost_count), 48'd0);
    request_length = 1'b1;
    step();
    request_length = 1'b0;
    @(negedge clk);
    chk("mid_rst_len",     48'(length),     48'd0);
    chk("mid_rst_len_rdy", 48'(length_rdy), 48'd1);
    data_ack = 1'b1;
    repeat (6) step();
    @(negedge clk) chk("mid_rst_quiet", 48'(data_rdy), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tagger_record_reader.md
Name: tagger_record_reader

Overview:
- Consumer end of the tagger engine's record interface.
- Captures the engine's one-cycle `record_rdy`/`record` strobes into a record FIFO.
- Serializes each 47-bit record into 16-bit words for the host transfer path, using a valid/ack handshake.
- Reports buffered word count on request and flags records dropped to overflow.

Parameters:
- DEPTH_LOG2, 4, record FIFO depth = 2**DEPTH_LOG2 records
- REC_W, 47, record width from tagger engine
- WORD_W, 16, output word width

Ports:
- clk  in  1  single system clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- record_rdy  in  1  one-cycle strobe, record valid
- record  in  REC_W  tagger record
- data  out  WORD_W  current output word
- data_rdy  out  1  data valid
- data_ack  in  1  consumer accepts word this cycle
- request_length  in  1  one-cycle length snapshot request
- length  out  16  words available (snapshot)
- length_rdy  out  1  one-cycle pulse, length valid
- overflow  out  1  sticky, record dropped since reset
- lost_count  out  16  dropped records, saturating

Behaviour:
- Reset: while rst_n=0 at a clk edge, all of the following clear:
  - outputs: data=0, data_rdy=0, length=0, length_rdy=0, overflow=0, lost_count=0
  - internal state: FIFO empty, FSM=IDLE
- Reset mid-transfer discards the partial record and all buffered records.
- Push:
  - A record_rdy sampled high is written to the FIFO when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle.
  - Otherwise the record is dropped: overflow<=1 and lost_count increments, saturating at 16'hFFFF.
- FSM states: IDLE, W0, W1, W2.
  - IDLE: if FIFO non-empty, pop into the 48-bit shift register {1'b0, rec}, then go to W0.
  - W0/W1/W2: data_rdy=1.
    - data = [15:0], [31:16], [47:32] respectively; bit 47 of the shift register is always 0.
    - On data_rdy&&data_ack, advance to the next state.
    - From W2: if FIFO non-empty, pop and go directly to W0 (back-to-back, no bubble); else go to IDLE.
  - No ack: data and data_rdy hold stable indefinitely.
  - data_ack while data_rdy=0 is ignored.
- Latency:
  - record_rdy at cycle N with FIFO empty and FSM IDLE -> FIFO write at N+1, pop at N+1 -> data_rdy=1 with word 0 at N+2.
  - Sustained throughput: 1 word/cycle with continuous ack.
- Length:
  - On request_length at cycle N: length <= WORDS_PER_REC*fifo_count + words remaining in current record (3/2/1 in W0/W1/W2, 0 in IDLE), computed from state at N.
  - length_rdy=1 for cycle N+1 only.
  - Saturates at 16'hFFFF; it cannot exceed this for DEPTH_LOG2<=12.
  - A request coinciding with a push/pop uses the pre-edge state.

Optional Feature:
- Macro: RECORD_MARKER_EN.
- Defined:
  - FSM gains state W3, which emits 16'hA5A5 after W2.
  - WORDS_PER_REC=4.
  - The W2->W0/IDLE transition moves to W3.
  - The length remaining term becomes 4/3/2/1.
- Undefined: 3 words per record, no marker, WORDS_PER_REC=3.

Decomposition:
- Package tagger_pkg:
  - REC_W, WORD_W, WORDS_PER_REC (macro-dependent)
  - MARKER_WORD=16'hA5A5
  - reader state enum
- Sub-module record_fifo:
  - synchronous single-clock FIFO with push, pop, full, empty, count
  - same clk/rst_n
  - first-word not exposed until pop (registered read)
- Serializer FSM, length and overflow logic stay in the top.

Test Plan:
- Single record:
  - Stimulus: record=47'h1234_5678_9ABC, one strobe, data_ack held 1.
  - Expect: words 16'h9ABC, 16'h5678, 16'h1234 on consecutive cycles starting 2 cycles after the strobe, then data_rdy=0.
  - Marker build: additionally 16'hA5A5.
- Backpressure:
  - Stimulus: data_ack=0 for 10 cycles after data_rdy rises, then 1.
  - Expect: data stable at word 0 throughout, then 3 words in order with no duplicates.
- Overflow:
  - Stimulus: data_ack=0, 20 strobes with DEPTH=16.
  - Expect: the FSM holds 1 record and the FIFO fills with 16; the remaining 3 strobes are dropped, giving overflow=1 and lost_count=3. Draining yields exactly 17 records in order.
- Length snapshot:
  - Stimulus: 2 records buffered, FSM in W1 with a third record loaded; pulse request_length.
  - Expect: next cycle length=8 (6+2) and length_rdy high one cycle.
  - Marker build: 11.
- Simultaneous full push/pop:
  - Stimulus: FIFO full, strobe on the same cycle as W2 ack.
  - Expect: record accepted, overflow stays 0.
- Reset mid-word:
  - Stimulus: rst_n=0 for 1 cycle while in W1.
  - Expect: next cycle data_rdy=0, length request returns 0, lost_count=0.
